fp16_norm_sequencer: RTL and testbench

- Multi-cycle normalization controller for the half-precision adder/subtractor.
- Takes the raw post-add mantissa and the 5-bit exponent, and produces a normalized FP16 exponent/fraction pair.
- Moves the mantissa one bit per cycle and steps the exponent by +1/-1 in lockstep, sharing a single 5-bit increment/decrement step.
- Sits between the mantissa adder stage and the rounding/pack stage, with valid/ready handshakes on both sides.

---
 rtl/fp16_norm_sequencer_if.sv | 32 +++
 rtl/fp16_norm_sequencer.sv | 176 +++++++++++++++++
 tb/tb_fp16_norm_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fp16_norm_sequencer_if.sv
// rtl/fp16_norm_sequencer_if.sv - operand/result handshake bundle for the FP16 normalization sequencer
interface fp16_norm_sequencer_if #(
  parameter int EXP_W  = 5,
  parameter int MANT_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic              in_sticky;

  logic              out_valid;
  logic              out_ready;
  logic [EXP_W-1:0]  out_exp;
  logic [MANT_W-3:0] out_frac;
  logic              out_sticky;
  logic              out_zero;
  logic              out_ovf;
  logic              out_subn;

  // Upstream adder stage / downstream pack stage side
  modport master (
    output in_valid, in_exp, in_mant, in_sticky, out_ready,
    input  in_ready, out_valid, out_exp, out_frac, out_sticky, out_zero, out_ovf, out_subn
  );

  // Sequencer side
  modport slave (
    input  in_valid, in_exp, in_mant, in_sticky, out_ready,
    output in_ready, out_valid, out_exp, out_frac, out_sticky, out_zero, out_ovf, out_subn
  );
endinterface

// File: rtl/fp16_norm_sequencer.sv
// rtl/fp16_norm_sequencer.sv - one-bit-per-cycle FP16 post-add normalization controller
module fp16_norm_sequencer #(
  parameter int EXP_W  = 5,
  parameter int MANT_W = 12,
  parameter int CNT_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fp16_norm_sequencer_if.slave bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     shift_count
);
  localparam int FRAC_W = MANT_W - 2;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  typedef enum logic [2:0] {IDLE, CHECK, SHIFT_R, SHIFT_L, DONE} state_t;

  state_t state_q, state_d;

  logic [EXP_W-1:0]  exp_q;
  logic [MANT_W-1:0] mant_q;
  logic              sticky_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              zero_q;
  logic              ovf_q;
  logic              in_ready_q;

  logic              out_valid_q;
  logic [EXP_W-1:0]  out_exp_q;
  logic [FRAC_W-1:0] out_frac_q;
  logic              out_sticky_q;
  logic              out_zero_q;
  logic              out_ovf_q;
  logic              out_subn_q;

  logic              accept;
  logic              handshake;
  logic [EXP_W-1:0]  exp_step;
  logic [MANT_W-1:0] mant_shl;
  logic [MANT_W-1:0] mant_shr;
  logic              fin_subn;
  logic [EXP_W-1:0]  fin_exp;
  logic [FRAC_W-1:0] fin_frac;

  assign accept    = (state_q == IDLE) && bus.in_valid && in_ready_q;
  assign handshake = out_valid_q && bus.out_ready;

  // Single shared exponent stepper: +1 while shifting right, -1 (add all-ones) otherwise
  assign exp_step = exp_q + ((state_q == SHIFT_R) ? EXP_ONE : EXP_MAX);
  assign mant_shl = {mant_q[MANT_W-2:0], 1'b0};
  assign mant_shr = {1'b0, mant_q[MANT_W-1:1]};

  // Final result formatting: zero beats subnormal beats overflow
  assign fin_subn = !zero_q && !mant_q[MANT_W-2];
  assign fin_exp  = zero_q   ? '0 :
                    fin_subn ? '0 :
                    ovf_q    ? EXP_MAX : exp_q;
  assign fin_frac = (zero_q || ovf_q) ? '0 : mant_q[FRAC_W-1:0];

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = CHECK;
      end
      CHECK: begin
        if (mant_q == '0)             state_d = DONE;
        else if (mant_q[MANT_W-1])    state_d = SHIFT_R;
        else if (mant_q[MANT_W-2])    state_d = DONE;
        else if (exp_q == EXP_ONE)    state_d = DONE;
        else                          state_d = SHIFT_L;
      end
      SHIFT_R: state_d = DONE;
      SHIFT_L: begin
        if (mant_shl[MANT_W-2] || (exp_step == EXP_ONE)) state_d = DONE;
      end
      DONE: begin
        if (handshake) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; in_ready is registered so it rises one edge after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == IDLE);
    end
  end

  // Working exponent/mantissa datapath, stepped one bit per cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q    <= '0;
      mant_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            exp_q    <= (bus.in_exp == '0) ? EXP_ONE : bus.in_exp;
            mant_q   <= bus.in_mant;
            sticky_q <= bus.in_sticky;
            cnt_q    <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
          end
        end
        CHECK: begin
          if (mant_q == '0) begin
            zero_q <= 1'b1;
            exp_q  <= '0;
          end
        end
        SHIFT_R: begin
          mant_q   <= mant_shr;
          sticky_q <= sticky_q | mant_q[0];
          exp_q    <= exp_step;
          if (exp_step == EXP_MAX) begin
            ovf_q              <= 1'b1;
            mant_q[FRAC_W-1:0] <= '0;
          end
        end
        SHIFT_L: begin
          mant_q <= mant_shl;
          exp_q  <= exp_step;
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result register: captured on the first DONE cycle, held until the downstream handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_exp_q    <= '0;
      out_frac_q   <= '0;
      out_sticky_q <= 1'b0;
      out_zero_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_subn_q   <= 1'b0;
    end else if ((state_q == DONE) && !out_valid_q) begin
      out_valid_q  <= 1'b1;
      out_exp_q    <= fin_exp;
      out_frac_q   <= fin_frac;
      out_sticky_q <= sticky_q;
      out_zero_q   <= zero_q;
      out_ovf_q    <= ovf_q;
      out_subn_q   <= fin_subn;
    end else if (handshake) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_exp    = out_exp_q;
  assign bus.out_frac   = out_frac_q;
  assign bus.out_sticky = out_sticky_q;
  assign bus.out_zero   = out_zero_q;
  assign bus.out_ovf    = out_ovf_q;
  assign bus.out_subn   = out_subn_q;
  assign busy           = (state_q != IDLE);
  assign shift_count    = cnt_q;
endmodule

// File: tb/tb_fp16_norm_sequencer.sv
// tb/tb_fp16_norm_sequencer.sv - vector table and scoreboard bench for fp16_norm_sequencer
module tb_fp16_norm_sequencer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       busy;
  logic [3:0] shift_count;

  fp16_norm_sequencer_if #(.EXP_W(5), .MANT_W(12)) bus();

  fp16_norm_sequencer #(.EXP_W(5), .MANT_W(12), .CNT_W(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .busy(busy),
    .shift_count(shift_count)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  e;
    logic [11:0] m;
    logic        s;
    logic [4:0]  oe;
    logic [9:0]  of;
    logic        os;
    logic        oz;
    logic        oo;
    logic        osub;
    logic [3:0]  cnt;
    int          lat;
  } vec_t;

  vec_t vecs[13];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_in(input vec_t v, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.in_exp    = v.e;
    bus.in_mant   = v.m;
    bus.in_sticky = v.s;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 50 && !bus.in_ready; i++) @(negedge clk);
    if (!bus.in_ready) begin
      chk("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(v);
    #1 bus.in_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic check_out(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb[0];
    chk({tag, "_valid"},  int'(bus.out_valid),  1);
    chk({tag, "_exp"},    int'(bus.out_exp),    int'(e.oe));
    chk({tag, "_frac"},   int'(bus.out_frac),   int'(e.of));
    chk({tag, "_sticky"}, int'(bus.out_sticky), int'(e.os));
    chk({tag, "_zero"},   int'(bus.out_zero),   int'(e.oz));
    chk({tag, "_ovf"},    int'(bus.out_ovf),    int'(e.oo));
    chk({tag, "_subn"},   int'(bus.out_subn),   int'(e.osub));
    chk({tag, "_cnt"},    int'(shift_count),    int'(e.cnt));
    chk({tag, "_inrdy"},  int'(bus.in_ready),   0);
  endtask

  task automatic run_vec(input vec_t v, input string tag, input int hold);
    bit ok;
    int lat;
    drive_in(v, ok);
    if (!ok) return;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_latency"}, lat, v.lat);
    if (lat < 0) begin
      void'(sb.pop_front());
      return;
    end
    check_out(tag);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_out($sformatf("%s_hold%0d", tag, h));
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    void'(sb.pop_front());
    chk({tag, "_post_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_post_inrdy"}, int'(bus.in_ready), 1);
    chk({tag, "_post_busy"},  int'(busy), 0);
  endtask

  initial begin
    bit ok;
    int spurious;

    //          e      m        s     oe     of       os    oz    oo    osub  cnt    lat
    vecs[0]  = '{5'd15, 12'h400, 1'b0, 5'd15, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  2};
    vecs[1]  = '{5'd15, 12'h801, 1'b0, 5'd16, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  3};
    vecs[2]  = '{5'd15, 12'h040, 1'b0, 5'd11, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4,  6};
    vecs[3]  = '{5'd3,  12'h010, 1'b0, 5'd0,  10'h040, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2,  4};
    vecs[4]  = '{5'd30, 12'h800, 1'b0, 5'd31, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  3};
    vecs[5]  = '{5'd15, 12'h000, 1'b0, 5'd0,  10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  2};
    vecs[6]  = '{5'd0,  12'h400, 1'b1, 5'd1,  10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  2};
    vecs[7]  = '{5'd20, 12'h001, 1'b0, 5'd10, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10, 12};
    vecs[8]  = '{5'd1,  12'h200, 1'b0, 5'd0,  10'h200, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  2};
    vecs[9]  = '{5'd15, 12'h7FF, 1'b1, 5'd15, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  2};
    vecs[10] = '{5'd10, 12'hFFF, 1'b0, 5'd11, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  3};
    vecs[11] = '{5'd2,  12'h0C0, 1'b0, 5'd0,  10'h180, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1,  3};
    vecs[12] = '{5'd30, 12'h801, 1'b1, 5'd31, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  3};

    bus.in_valid  = 1'b0;
    bus.in_exp    = '0;
    bus.in_mant   = '0;
    bus.in_sticky = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_inrdy", int'(bus.in_ready), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_cnt",   int'(shift_count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_inrdy_after", int'(bus.in_ready), 1);

    // Vector table
    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("v%0d", i), 0);

    // Backpressure: hold result for 5 cycles
    run_vec(vecs[2], "bp", 5);

    // Reset in the middle of a long left-normalization
    drive_in(vecs[7], ok);
    if (ok) begin
      repeat (4) @(posedge clk);
      #1;
      chk("mid_busy_before", int'(busy), 1);
      #1 reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", int'(bus.out_valid), 0);
      chk("mid_rst_busy",  int'(busy), 0);
      chk("mid_rst_cnt",   int'(shift_count), 0);
      chk("mid_rst_inrdy", int'(bus.in_ready), 0);
      sb.delete();
      @(negedge clk);
      reset_n = 1'b1;
      spurious = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1;
        if (bus.out_valid || busy) spurious++;
      end
      chk("mid_rst_spurious", spurious, 0);
      chk("mid_rst_inrdy_after", int'(bus.in_ready), 1);
    end

    // Recovery after reset
    run_vec(vecs[1], "recover", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
